// File: rtl/zero_unpadding.sv
// zero_unpadding: strips the one-word border from a padded
// ROWS x COLS frame and writes interior words to a FIFO.
module zero_unpadding #(
  parameter int WL   = 96,
  parameter int ROWS = 14,
  parameter int COLS = 17
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [WL-1:0] in,
  input  logic          in_valid,
  input  logic          start,
  input  logic          wrfull,
  output logic [WL-1:0] out,
  output logic          wrreq,
  output logic          busy,
  output logic          done,
  output logic          ovf
);

  localparam int RW = $clog2(ROWS + 1);
  localparam int CW = $clog2(COLS + 1);

  localparam logic [RW-1:0] ROW_ONE  = RW'(1);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS);
  localparam logic [CW-1:0] COL_ONE  = CW'(1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [WL-1:0] out_q, out_d;
  logic          wrreq_q, wrreq_d;
  logic          ovf_q, ovf_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic interior;
  logic last_beat;

  // Position decode on the current counters, before they advance.
  always_comb begin
    interior  = (row_q >= ROW_TWO) && (row_q < ROW_LAST) &&
                (col_q >= COL_TWO) && (col_q < COL_LAST);
    last_beat = (row_q == ROW_LAST) && (col_q == COL_LAST);
  end

  // Frame control, counter advance and write/drop decision.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    out_d   = out_q;
    wrreq_d = 1'b0;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          row_d   = ROW_ONE;
          col_d   = COL_ONE;
          ovf_d   = 1'b0;
        end
      end
      RUN: begin
        if (in_valid) begin
          if (interior) begin
            if (!wrfull) begin
              out_d   = in;
              wrreq_d = 1'b1;
            end else begin
              ovf_d = 1'b1;
            end
          end
          if (last_beat) begin
            state_d = DONE;
            row_d   = ROW_ONE;
            col_d   = COL_ONE;
          end else if (col_q == COL_LAST) begin
            col_d = COL_ONE;
            row_d = row_q + ROW_ONE;
          end else begin
            col_d = col_q + COL_ONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and registered outputs; reset aborts any frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      row_q   <= ROW_ONE;
      col_q   <= COL_ONE;
      out_q   <= '0;
      wrreq_q <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      out_q   <= out_d;
      wrreq_q <= wrreq_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out   = out_q;
  assign wrreq = wrreq_q;
  assign ovf   = ovf_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_zero_unpadding.sv
// tb_zero_unpadding: directed frames with a scoreboard queue
// of expected interior words.
module tb_zero_unpadding;

  localparam int WL   = 96;
  localparam int ROWS = 14;
  localparam int COLS = 17;
  localparam int NB   = ROWS * COLS;

  logic          clk = 1'b0;
  logic          rst;
  logic [WL-1:0] din;
  logic          in_valid;
  logic          start;
  logic          wrfull;
  logic [WL-1:0] dout;
  logic          wrreq;
  logic          busy;
  logic          done;
  logic          ovf;

  int checks = 0;
  int errors = 0;
  int writes = 0;
  logic [WL-1:0] exp_q[$];

  zero_unpadding #(.WL(WL), .ROWS(ROWS), .COLS(COLS)) dut (
    .clk(clk),
    .rst(rst),
    .in(din),
    .in_valid(in_valid),
    .start(start),
    .wrfull(wrfull),
    .out(dout),
    .wrreq(wrreq),
    .busy(busy),
    .done(done),
    .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [WL-1:0] obs,
                     input logic [WL-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write must match the oldest expected word.
  always @(negedge clk) begin
    if (rst === 1'b1 && wrreq === 1'b1) begin
      writes++;
      if (exp_q.size() == 0) begin
        chk("unexpected_write", dout, '1);
      end else begin
        chk("write_data", dout, exp_q.pop_front());
      end
    end
  end

  function automatic bit is_interior(input int k);
    int r, c;
    r = (k - 1) / COLS + 1;
    c = (k - 1) % COLS + 1;
    return (r >= 2) && (r <= ROWS - 1) && (c >= 2) && (c <= COLS - 1);
  endfunction

  task automatic run_frame(input bit toggle, input int full_at,
                           input int restart_at, input int abort_at,
                           input int exp_writes, input bit exp_ovf);
    writes = 0;
    @(negedge clk);
    start    = 1'b1;
    in_valid = 1'b1;
    din      = WL'(999);
    wrfull   = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", WL'(busy), WL'(1));
    chk("ovf_cleared", WL'(ovf), WL'(0));
    for (int k = 1; k <= NB; k++) begin
      if (toggle) begin
        in_valid = 1'b0;
        din      = WL'(5000 + k);
        @(negedge clk);
      end
      in_valid = 1'b1;
      din      = WL'(k);
      wrfull   = (k == full_at);
      start    = (k == restart_at);
      if (is_interior(k) && k != full_at) exp_q.push_back(WL'(k));
      @(negedge clk);
      start  = 1'b0;
      wrfull = 1'b0;
      if (k == full_at) chk("ovf_set", WL'(ovf), WL'(1));
      if (k == abort_at) begin
        in_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("abort_out", dout, '0);
        chk("abort_wrreq", WL'(wrreq), WL'(0));
        chk("abort_busy", WL'(busy), WL'(0));
        chk("abort_ovf", WL'(ovf), WL'(0));
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        return;
      end
    end
    in_valid = 1'b0;
    chk("done_pulse", WL'(done), WL'(1));
    chk("busy_in_done", WL'(busy), WL'(1));
    @(negedge clk);
    chk("done_clear", WL'(done), WL'(0));
    chk("busy_clear", WL'(busy), WL'(0));
    chk("ovf_end", WL'(ovf), WL'(exp_ovf));
    chk("write_count", WL'(writes), WL'(exp_writes));
    chk("queue_empty", WL'(exp_q.size()), WL'(0));
  endtask

  initial begin
    rst      = 1'b0;
    din      = '0;
    in_valid = 1'b0;
    start    = 1'b0;
    wrfull   = 1'b0;
    #1;
    chk("rst_out", dout, '0);
    chk("rst_wrreq", WL'(wrreq), WL'(0));
    chk("rst_busy", WL'(busy), WL'(0));
    chk("rst_done", WL'(done), WL'(0));
    chk("rst_ovf", WL'(ovf), WL'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Idle traffic without start must be ignored.
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      din      = WL'(19 + i);
      @(negedge clk);
      chk("idle_wrreq", WL'(wrreq), WL'(0));
      chk("idle_busy", WL'(busy), WL'(0));
    end
    in_valid = 1'b0;

    run_frame(1'b0, 0, 0, 0, 180, 1'b0);
    run_frame(1'b1, 0, 0, 0, 180, 1'b0);
    run_frame(1'b0, 19, 0, 0, 179, 1'b1);
    run_frame(1'b0, 0, 0, 100, 0, 1'b0);
    run_frame(1'b0, 0, 0, 0, 180, 1'b0);
    run_frame(1'b0, 0, 50, 0, 180, 1'b0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/zero_unpadding.md
Name: zero_unpadding

Overview:
- Inverse of the zero-padding stage: accepts a padded 14 x 17 frame of 96-bit words, one word per valid beat, in raster order (row-major, column fastest).
- Strips the one-word border and writes only the 12 x 15 interior words into a downstream FIFO, using wrreq/wrfull handshaking.
- Sits between the feature-map compute output and the SPI transmit FIFO. Tracks frame position with row/column counters under a small frame-control FSM.

Parameters:
WL, 96, word width in bits
ROWS, 14, padded frame rows
COLS, 17, padded frame columns

Ports:
clk  input  1  system clock; all state changes on the rising edge
rst  input  1  asynchronous, active-low reset
in  input  WL  padded input word
in_valid  input  1  in carries a frame beat this cycle
start  input  1  single-cycle pulse that arms capture of one frame
wrfull  input  1  downstream FIFO full
out  output  WL  registered interior word toward the FIFO
wrreq  output  1  FIFO write request, one cycle per interior word
busy  output  1  high while a frame is in progress (RUN or DONE)
done  output  1  one-cycle pulse after the last beat of a frame
ovf  output  1  sticky flag: at least one interior word was dropped because wrfull was high

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE; row and col counters go to 1.
  - out=0, wrreq=0, busy=0, done=0, ovf=0.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on start=1. The row and col counters load 1, and ovf clears on this same edge.
  - In IDLE, in_valid is ignored.
  - RUN -> DONE on the edge that consumes the beat at row=ROWS, col=COLS.
  - DONE -> IDLE unconditionally after one cycle. done=1 only while in DONE.
  - busy=1 in RUN and DONE.
- Beat counting:
  - Beats count only in RUN. A beat presented on the same cycle as start is not counted; the first counted beat is the cycle after start.
  - Each in_valid=1 cycle in RUN advances col. At col=COLS, col wraps to 1 and row increments.
  - Gaps (in_valid=0) hold both counters.
- Interior test, evaluated on the current counter values:
  - A beat is interior when 2 <= row <= ROWS-1 and 2 <= col <= COLS-1.
  - Every other beat (border) is discarded and never written.
- Writing interior beats:
  - Latency 1: an interior beat with wrfull=0 gives out<=in and wrreq=1 on the next cycle.
  - An interior beat with wrfull=1 is dropped: wrreq=0 and ovf<=1. The counters still advance, so no stall or backpressure reaches upstream.
  - When wrreq=0, out holds its last value.
  - Exactly (ROWS-2)*(COLS-2)=180 writes per frame when wrfull never asserts.
- start while in RUN or DONE is ignored: no counter reload, no ovf clear.
- ovf stays 1 until reset or the next accepted start.
- Reset mid-frame aborts the frame immediately. The next start begins a clean frame.

Test Plan:
- Full frame, continuous valid, in = beat index 1..238 → 180 wrreq pulses. First write is out=19, one cycle after beat 19; last write is out=220. done=1 exactly one cycle after beat 238, then busy=0; ovf=0.
- Same frame with in_valid toggling 1/0 every cycle → identical 180-word sequence 19..220, with each wrreq one cycle after its beat. done arrives after the 238th valid beat.
- wrfull=1 only during beat 19 → no write for word 19; ovf=1 from the next cycle. 179 writes follow (first out=20), and ovf stays 1 after done until the next start clears it.
- Reset asserted at beat 100 → all outputs 0 asynchronously and state IDLE. A new start and full frame then produces the correct 180 words 19..220.
- start pulsed again at beat 50 of a running frame → ignored: output sequence and done timing unchanged versus the clean run.
- in_valid=1 with words while IDLE and no start → no wrreq, busy=0, counters stay at 1.
